// File: rtl/axi_wr_burst_master_if.sv
// axi_wr_burst_master_if
//   AXI3 write-channel bundle (AW, W, B) between a write master and a slave.
//   master modport: drives AW*/W*/BREADY, samples AWREADY/WREADY/B*.
//   slave modport : the mirror image.
interface axi_wr_burst_master_if;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [3:0]  WID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic        BREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    output BREADY,
    input  BID, BRESP, BVALID
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    input  BREADY,
    output BID, BRESP, BVALID
  );
endinterface

// File: rtl/axi_wr_burst_master.sv
// axi_wr_burst_master
//   Single-outstanding AXI3 write burst engine. Accepts one command
//   (addr/len/size/id), issues AW (INCR), streams len+1 local data beats
//   onto W with WLAST on the final beat, then collects the B response and
//   pulses done with the response code and an ID-mismatch flag.
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   cmd_*               : command handshake and fields
//   wd_*                : local data-beat handshake, data, strobes
//   axi (master)        : AXI3 AW/W/B channels
//   done/done_resp/
//   done_id_err         : one-cycle completion pulse with response status
//   busy                : FSM not idle
// Configuration
//   AXI_WR_MST_TIMEOUT_EN : when defined, RESP gives up after TIMEOUT_CYC
//                           cycles without BVALID and reports SLVERR.
module axi_wr_burst_master #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [31:0]                  cmd_addr,
  input  logic [3:0]                   cmd_len,
  input  logic [2:0]                   cmd_size,
  input  logic [3:0]                   cmd_id,
  input  logic                         wd_valid,
  output logic                         wd_ready,
  input  logic [31:0]                  wd_data,
  input  logic [3:0]                   wd_strb,
  axi_wr_burst_master_if.master        axi,
  output logic                         done,
  output logic [1:0]                   done_resp,
  output logic                         done_id_err,
  output logic                         busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e      state_q;
  logic        cmd_ready_q, busy_q;
  logic [3:0]  len_q, id_q;
  logic [31:0] awaddr_q;
  logic [2:0]  awsize_q;
  logic        awvalid_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        wlast_q, wvalid_q;
  logic        bready_q;
  logic [4:0]  loaded_q;  // beats taken from local side, 0..16
  logic [3:0]  beat_q;    // beats issued on W
  logic        done_q, done_id_err_q;
  logic [1:0]  done_resp_q;
  logic        wd_hs, w_hs;

`ifdef AXI_WR_MST_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] tmo_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // One-entry W output register: refill when empty or draining this cycle.
  assign wd_ready = (state_q == DATA) && (!wvalid_q || axi.WREADY)
                    && (loaded_q <= {1'b0, len_q});
  assign wd_hs    = wd_valid && wd_ready;
  assign w_hs     = wvalid_q && axi.WREADY;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      len_q         <= '0;
      id_q          <= '0;
      awaddr_q      <= '0;
      awsize_q      <= '0;
      awvalid_q     <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      wlast_q       <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      loaded_q      <= '0;
      beat_q        <= '0;
      done_q        <= 1'b0;
      done_resp_q   <= '0;
      done_id_err_q <= 1'b0;
`ifdef AXI_WR_MST_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            awaddr_q    <= cmd_addr;
            len_q       <= cmd_len;
            awsize_q    <= cmd_size;
            id_q        <= cmd_id;
            awvalid_q   <= 1'b1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            loaded_q    <= '0;
            beat_q      <= '0;
            state_q     <= ADDR;
          end
        end
        ADDR: begin
          if (axi.AWREADY) begin
            awvalid_q <= 1'b0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (wd_hs) begin
            wdata_q  <= wd_data;
            wstrb_q  <= wd_strb;
            wlast_q  <= (loaded_q == {1'b0, len_q});
            wvalid_q <= 1'b1;
            loaded_q <= loaded_q + 5'd1;
          end else if (w_hs) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
          end
          if (w_hs) begin
            beat_q <= beat_q + 4'd1;
            if (beat_q == len_q) begin
              bready_q <= 1'b1;
              state_q  <= RESP;
`ifdef AXI_WR_MST_TIMEOUT_EN
              tmo_q    <= '0;
`endif
            end
          end
        end
        RESP: begin
`ifdef AXI_WR_MST_TIMEOUT_EN
          tmo_q <= tmo_q + TW'(1);
`endif
          if (axi.BVALID) begin
            done_q        <= 1'b1;
            done_resp_q   <= axi.BRESP;
            done_id_err_q <= (axi.BID != id_q);
            bready_q      <= 1'b0;
            busy_q        <= 1'b0;
            cmd_ready_q   <= 1'b1;
            state_q       <= IDLE;
          end
`ifdef AXI_WR_MST_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            done_q        <= 1'b1;
            done_resp_q   <= 2'b10;
            done_id_err_q <= 1'b0;
            bready_q      <= 1'b0;
            busy_q        <= 1'b0;
            cmd_ready_q   <= 1'b1;
            state_q       <= IDLE;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign done_resp   = done_resp_q;
  assign done_id_err = done_id_err_q;

  assign axi.AWID    = id_q;
  assign axi.AWADDR  = awaddr_q;
  assign axi.AWLEN   = len_q;
  assign axi.AWSIZE  = awsize_q;
  assign axi.AWBURST = 2'b01;
  assign axi.AWVALID = awvalid_q;
  assign axi.WID     = id_q;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = wstrb_q;
  assign axi.WLAST   = wlast_q;
  assign axi.WVALID  = wvalid_q;
  assign axi.BREADY  = bready_q;

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// tb_axi_wr_burst_master
//   Directed bench: the bench plays command source, data source and AXI
//   slave; every burst is checked against hand-derived expectations.
module tb_axi_wr_burst_master;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [3:0]  cmd_id = '0;
  logic        wd_valid = 1'b0;
  logic        wd_ready;
  logic [31:0] wd_data = '0;
  logic [3:0]  wd_strb = '0;
  logic        done;
  logic [1:0]  done_resp;
  logic        done_id_err;
  logic        busy;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;

  axi_wr_burst_master_if axi_if ();

  axi_wr_burst_master #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_id(cmd_id),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .axi(axi_if),
    .done(done), .done_resp(done_resp), .done_id_err(done_id_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] a, input int i);
    return a ^ 32'hC0DE_0000 ^ 32'(i * 17);
  endfunction

  function automatic logic [3:0] beat_strb(input int i);
    return 4'hF ^ 4'(i);
  endfunction

  // aw_delay: cycles AWREADY is held low; wtoggle: WREADY alternates 0/1;
  // b_delay: loop cycles before BVALID rises; abort_at: reset after that many
  // W beats (<0 = never); tmo_mode: BVALID never rises.
  task automatic do_burst(input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [3:0] id,
                          input logic [3:0] bid, input logic [1:0] bresp,
                          input int aw_delay, input bit wtoggle, input int b_delay,
                          input int abort_at, input bit tmo_mode, input bit chk_lat);
    int beats = 0, loaded = 0, aw_wait = 0, first_w = -1, last_w = -1, acc = 0, t = 0;
    bit prev_stall = 0, got_done = 0;
    logic [31:0] prev_wdata = '0;
    logic [1:0] exp_resp = tmo_mode ? 2'b10 : bresp;
    logic exp_err = tmo_mode ? 1'b0 : (bid != id);

    @(negedge clk);
    while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
    check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_id = id;
    wd_valid = 1'b0;
    axi_if.AWREADY = (aw_delay == 0);
    axi_if.WREADY  = 1'b1;
    axi_if.BVALID  = (!tmo_mode && b_delay == 0);
    axi_if.BID     = bid;
    axi_if.BRESP   = bresp;
    @(negedge clk);
    acc = cyc;
    cmd_valid = 1'b0;
    check("aw_after_accept", {29'b0, axi_if.AWVALID, busy, cmd_ready}, 32'b110);
    check("aw_addr", axi_if.AWADDR, addr);
    check("aw_fields", {19'b0, axi_if.AWID, axi_if.AWLEN, axi_if.AWSIZE, axi_if.AWBURST},
          {19'b0, id, len, size, 2'b01});

    for (int k = 0; k < 300; k++) begin
      if (done) begin
        got_done = 1;
        axi_if.BVALID = 1'b0;
        check("done_resp", {30'b0, done_resp}, {30'b0, exp_resp});
        check("done_id_err", {31'b0, done_id_err}, {31'b0, exp_err});
        check("idle_at_done", {30'b0, cmd_ready, busy}, 32'b10);
        check("beat_count", beats, 32'(len) + 1);
        if (chk_lat) begin
          check("first_w_lat", first_w, acc + 3);
          check("w_consecutive", last_w - first_w, 32'(len));
          check("done_lat", cyc, last_w + (tmo_mode ? 16 : 1));
        end
        break;
      end
      if (axi_if.AWVALID)
        check("aw_stable", axi_if.AWADDR ^ {15'b0, axi_if.AWID, axi_if.AWLEN, axi_if.AWSIZE, axi_if.AWBURST},
              addr ^ {15'b0, id, len, size, 2'b01});
      if (prev_stall)
        check("w_stall_stable", axi_if.WDATA, prev_wdata);
      if (beats < 32'(len) + 1)
        check("bready_low_early", {31'b0, axi_if.BREADY}, 32'd0);

      if (axi_if.AWVALID) begin
        axi_if.AWREADY = (aw_wait >= aw_delay);
        aw_wait++;
      end
      axi_if.WREADY = wtoggle ? ~axi_if.WREADY : 1'b1;
      if (!tmo_mode && k >= b_delay) axi_if.BVALID = 1'b1;
      wd_valid = (loaded <= 32'(len));
      wd_data  = beat_data(addr, loaded);
      wd_strb  = beat_strb(loaded);
      #1;
      if (wd_valid && wd_ready) loaded++;
      if (axi_if.WVALID && axi_if.WREADY) begin
        check("w_data", axi_if.WDATA, beat_data(addr, beats));
        check("w_strb_last_id", {23'b0, axi_if.WSTRB, axi_if.WLAST, axi_if.WID},
              {23'b0, beat_strb(beats), beats == 32'(len), id});
        if (first_w < 0) first_w = cyc + 1;
        last_w = cyc + 1;
        beats++;
      end
      prev_stall = axi_if.WVALID && !axi_if.WREADY;
      prev_wdata = axi_if.WDATA;
      if (abort_at >= 0 && beats == abort_at) begin
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_mid_burst", {25'b0, axi_if.AWVALID, axi_if.WVALID, axi_if.BREADY,
              axi_if.WLAST, busy, done, wd_ready}, 32'd0);
        wd_valid = 1'b0; axi_if.WREADY = 1'b0; axi_if.AWREADY = 1'b0; axi_if.BVALID = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      @(negedge clk);
    end
    if (!got_done) check("done_seen", 32'd0, 32'd1);
    wd_valid = 1'b0;
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    axi_if.AWREADY = 1'b0; axi_if.WREADY = 1'b0; axi_if.BVALID = 1'b0;
    axi_if.BID = '0; axi_if.BRESP = '0;
    #12;
    check("reset_ctrl", {24'b0, cmd_ready, busy, done, done_id_err, axi_if.AWVALID,
          axi_if.WVALID, axi_if.BREADY, axi_if.WLAST}, 32'd0);
    check("reset_data", axi_if.AWADDR | axi_if.WDATA | {28'b0, axi_if.WSTRB}, 32'd0);
    check("reset_resp", {30'b0, done_resp}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    do_burst(32'h0000_1000, 4'd3, 3'd2, 4'd5, 4'd5, 2'b00, 0, 0, 0, -1, 0, 1);
    do_burst(32'h0000_2000, 4'd5, 3'd2, 4'd9, 4'd9, 2'b01, 3, 1, 4, -1, 0, 0);
    do_burst(32'h0000_3004, 4'd0, 3'd2, 4'd1, 4'd1, 2'b11, 0, 0, 0, -1, 0, 1);
    do_burst(32'h0000_4000, 4'd1, 3'd2, 4'd2, 4'd7, 2'b00, 1, 0, 0, -1, 0, 0);
    do_burst(32'h0000_5000, 4'd3, 3'd2, 4'd4, 4'd4, 2'b00, 0, 0, 0, 2, 0, 0);
    do_burst(32'h0000_6000, 4'd2, 3'd2, 4'd6, 4'd6, 2'b00, 0, 0, 0, -1, 0, 1);
`ifdef AXI_WR_MST_TIMEOUT_EN
    do_burst(32'h0000_7000, 4'd1, 3'd2, 4'd3, 4'd8, 2'b00, 0, 0, 0, -1, 1, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_wr_burst_master.md
# axi_wr_burst_master

AXI3 write-channel master engine that is the initiator counterpart of the slave-side driver/monitor environment. It accepts one burst command plus a stream of data beats from local logic, issues the AW address phase, drives the W beats with WLAST, and collects the B response. The block serves as the RTL stimulus source on the master side of the AXI interface and as a reusable write engine for DMA-style blocks.

## Interface
- TIMEOUT_CYC, 256: B-channel watchdog limit in cycles. Used only under the macro; must be at least 2.
- clk  input  1  single clock; all logic is on the posedge.
- rst  input  1  asynchronous reset, active-low.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_addr  input  32  start address.
- cmd_len  input  4  beats minus 1 (AXI3 AWLEN).
- cmd_size  input  3  AWSIZE.
- cmd_id  input  4  AWID/WID.
- wd_valid / wd_ready  in / out  1  local data-beat handshake.
- wd_data  input  32  beat data.
- wd_strb  input  4  beat strobes.
- AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID  output  4/32/4/3/2/1  write address channel.
- AWREADY  input  1
- WID, WDATA, WSTRB, WLAST, WVALID  output  4/32/4/1/1  write data channel.
- WREADY  input  1
- BREADY  output  1
- BID, BRESP, BVALID  input  4/2/1
- done  output  1  one-cycle completion pulse.
- done_resp  output  2  final response code.
- done_id_err  output  1  BID ≠ command ID (valid with done).
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- The FSM has four states: IDLE, ADDR, DATA, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/len/size/id and go to ADDR.
- ADDR: AWVALID=1. AW fields come from the latched command, and AWBURST=2'b01 (INCR). All AW fields stay stable until AWREADY. On the handshake, go to DATA.
- DATA: W beats are issued from a one-entry output register.
  - wd_ready = (!WVALID || WREADY) && (loaded < len+1).
  - A wd handshake loads WDATA/WSTRB and sets WVALID.
  - WVALID drops after a WREADY handshake if no new beat is loaded.
  - WLAST=1 exactly on beat index len. WID is the latched id.
  - A 4-bit issued-beat counter tracks progress. When the WLAST beat handshakes, go to RESP.
- RESP: BREADY=1. On BVALID:
  - capture BRESP into done_resp;
  - set done_id_err = (BID != id);
  - pulse done;
  - go to IDLE.
- W payload stays stable while WVALID=1 and WREADY=0.
- No new command is accepted until done. Only one burst is outstanding at a time.
- Address/ID ordering rules and 4 KB boundary checks belong to the command source, not this block.

## Timing
- Reset (async assert, sync release) sets: AWVALID=WVALID=BREADY=0, WLAST=0, done=0, done_resp=0, done_id_err=0, busy=0, cmd_ready=0 during reset, all AW/W data fields 0, FSM=IDLE, counters 0.
- Command accepted at edge N → AWVALID=1 at N+1.
- AWREADY already high at N+1 → first wd_ready at N+2. The first WVALID is the cycle after the first wd handshake.
- With zero backpressure, a len=L burst completes W in L+1 consecutive cycles after the first load.
- Last W handshake at edge M → BREADY=1 from M+1. A BVALID that is already high completes at M+1, and done is high at M+2.
- done is held for exactly one cycle. cmd_ready returns in the same cycle as done.
- Reset asserted mid-burst drops all valids immediately. No partial-burst recovery is attempted.
- BVALID while in ADDR or DATA is ignored: BREADY=0 in those states.
- cmd_len=0 gives a single beat with WLAST=1.

## Configuration
- AXI_WR_MST_TIMEOUT_EN defined:
  - a counter runs in RESP;
  - if BVALID is not seen within TIMEOUT_CYC cycles, pulse done with done_resp=2'b10 (SLVERR) and done_id_err=0, then return to IDLE;
  - a BVALID arriving later is ignored until the next RESP.
- Undefined: RESP waits indefinitely and no counter logic is present.

## Test plan
- Zero backpressure: addr=0x1000, len=3, id=5, all readies high, BRESP=0, BID=5.
  - AWVALID one cycle after cmd accept.
  - 4 consecutive W beats with WLAST only on beat 3 and WID=5.
  - done with done_resp=0 and done_id_err=0.
- Backpressure: AWREADY delayed 3 cycles and WREADY toggled 1/0.
  - AW and W payloads are stable while stalled.
  - No beat is dropped or duplicated.
  - Exactly len+1 W handshakes occur.
- Single beat: len=0.
  - One W beat with WLAST=1.
  - BRESP=2'b11 → done_resp=2'b11.
- ID mismatch: command id=2, BID=7.
  - done_id_err=1 at the done pulse.
- Reset asserted during DATA after 2 of 4 beats:
  - all valids go to 0 immediately, FSM is in IDLE, busy=0.
  - The next command runs cleanly.
- With AXI_WR_MST_TIMEOUT_EN and TIMEOUT_CYC=16, BVALID held low:
  - done at cycle 16 of RESP with done_resp=2'b10.
